psum_out_drain: RTL and testbench
=================================

// Module: psum_out_drain
// PURPOSE
//  Drains one core's output port. Captures each col*bw_psum partial-sum row when the core's
//  out_valid is high and buffers it in a small row FIFO. Streams the row to the host one psum
//  per beat, using a valid/ready handshake tagged with column and row index.
//  One instance per core, clocked in that core's domain (clk0 or clk1), fed by that core's slice of fullchip.out.
// PARAMETERS
//  col      8   psums per row (core columns)
//  bw_psum  20  width of one signed psum
//  depth    4   row FIFO depth in rows; power of two, >=2
//  row_w    8   width of the row tag counter
// PORTS
//  clk           in   1               core clock (rising edge)
//  reset         in   1               asynchronous, active-high reset
//  out_in        in   col*bw_psum     row from core; column k = bits [k*bw_psum +: bw_psum]
//  out_valid_in  in   1               row on out_in valid this cycle (single-cycle pulse per row)
//  o_data        out  bw_psum         current psum beat
//  o_col         out  $clog2(col)     column index of o_data
//  o_row         out  row_w           row tag of o_data
//  o_last        out  1               o_col == col-1
//  o_valid       out  1               beat valid
//  o_ready       in   1               host accepts beat
//  full          out  1               FIFO holds depth rows
//  empty         out  1               FIFO holds 0 rows
//  overflow      out  1               sticky: a row was dropped
// BEHAVIOUR
//  - Reset (async, immediate): count=0, wr/rd ptr=0, col_idx=0, row_tag=0, overflow=0.
//    So o_valid=0, empty=1, full=0, o_col=0, o_row=0, o_last=0. o_data is don't-care but not X in sim.
//    Reset mid-row discards all buffered rows, including any partially sent row.
//  - pop  = o_valid & o_ready & o_last.  push_ok = count<depth | pop.
//  - Push: out_valid_in & push_ok writes out_in to mem[wr_ptr] at the edge, and wr_ptr++.
//    Row visible at o_valid the next cycle, so latency from capture edge to first beat is 1 cycle.
//  - Drop: out_valid_in & ~push_ok leaves state unchanged and sets overflow=1 at the edge.
//    overflow clears only on reset.
//  - Simultaneous push and pop when full: both happen and count stays depth.
//    When empty, push alone; there is no fall-through in the same cycle.
//  - o_valid = ~empty. o_data = mem[rd_ptr][col_idx*bw_psum +: bw_psum], combinational from head.
//    o_col = col_idx, o_row = row_tag.
//  - Beat transfer (o_valid & o_ready): if col_idx==col-1, then col_idx<=0, rd_ptr++, row_tag++.
//    Otherwise col_idx++.
//  - Stall: while o_valid & ~o_ready, o_data/o_col/o_row/o_last hold stable and o_valid stays 1.
//  - Pointers are log2(depth) bits and wrap naturally. row_tag wraps 2^row_w-1 -> 0.
//    row_tag counts only delivered rows; dropped rows consume no tag.
//  - count is log2(depth)+1 bits. full = (count==depth), empty = (count==0), both registered-derived.
//  - Data passes bit-exact; no sign extension or rounding.
// STRUCTURE
//  - Shared package (fullchip_pkg): COL, BW_PSUM, the default PSUM_FIFO_DEPTH,
//    and the function clog2 for index widths.
//  - Sub-module: row_fifo (sync, single clock, depth x col*bw_psum, async reset, count/full/empty).
//    psum_out_drain adds the column serializer, row tag, and overflow logic around it.
// TESTING
//  - Reset then idle: o_valid=0, empty=1, full=0, overflow=0, o_row=0 for 20 cycles.
//  - One row, column k = k+1 (col=8), o_ready=1: 8 beats on consecutive cycles starting 1 cycle after capture.
//    Expect o_data 1..8, o_col 0..7, o_last only on 8th beat, o_row=0, then empty=1.
//  - o_ready toggled 1,0,0,1,...: beat values never change while stalled; 8 beats total, in order, no duplicates.
//  - o_ready=0, push 5 rows (depth=4): full=1 after 4th. 5th is dropped and overflow=1.
//    Release ready: exactly 4 rows out, tags 0..3, 5th row's data never appears.
//  - Full FIFO, out_valid_in on the same cycle as the 8th beat of the head row: push accepted, overflow stays 0, count stays 4.
//  - Assert reset mid-row (after 3 beats) with 2 rows queued: o_valid drops immediately.
//    After release, push a new row: it streams from o_col=0, o_row=0.
//  - Drain 256 single rows: o_row wraps 255 -> 0.

Source files
------------

// File: rtl/psum_out_drain_pkg.sv
// rtl/psum_out_drain_pkg.sv - shared sizing constants and index-width helper for the psum drain
package psum_out_drain_pkg;

    localparam int COL             = 8;
    localparam int BW_PSUM         = 20;
    localparam int PSUM_FIFO_DEPTH = 4;
    localparam int ROW_W           = 8;

    // Minimum of 1 so single-entry dimensions still produce a legal vector.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int COL_W = clog2(COL);

endpackage

// File: rtl/psum_out_drain_if.sv
// rtl/psum_out_drain_if.sv - host-side psum beat stream with column/row tags
interface psum_out_drain_if
    import psum_out_drain_pkg::*;
#(
    parameter int bw_psum = BW_PSUM,
    parameter int col_w   = COL_W,
    parameter int row_w   = ROW_W
) ();

    logic [bw_psum-1:0] o_data;
    logic [col_w-1:0]   o_col;
    logic [row_w-1:0]   o_row;
    logic               o_last;
    logic               o_valid;
    logic               o_ready;

    modport master (
        output o_data, o_col, o_row, o_last, o_valid,
        input  o_ready
    );

    modport slave (
        input  o_data, o_col, o_row, o_last, o_valid,
        output o_ready
    );

endinterface

// File: rtl/psum_out_drain_row_fifo.sv
// rtl/psum_out_drain_row_fifo.sv - single-clock row FIFO with combinational head read
module psum_out_drain_row_fifo
    import psum_out_drain_pkg::*;
#(
    parameter int width = COL * BW_PSUM,
    parameter int depth = PSUM_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [width-1:0] wr_data,
    input  logic             rd_en,
    output logic [width-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int ptr_w = clog2(depth);

    logic [width-1:0] mem [depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [ptr_w:0]   count;

    // Callers must gate wr_en with full/pop and only assert rd_en when non-empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (ptr_w + 1)'(depth));
    assign empty   = (count == '0);

endmodule

// File: rtl/psum_out_drain.sv
// rtl/psum_out_drain.sv - buffers core psum rows and serializes them to the host one psum per beat
module psum_out_drain
    import psum_out_drain_pkg::*;
#(
    parameter int col     = COL,
    parameter int bw_psum = BW_PSUM,
    parameter int depth   = PSUM_FIFO_DEPTH,
    parameter int row_w   = ROW_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*bw_psum-1:0] out_in,
    input  logic                   out_valid_in,
    psum_out_drain_if.master       host,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow
);

    localparam int col_w = clog2(col);

    logic [col*bw_psum-1:0] head;
    logic [col_w-1:0]       col_idx;
    logic [row_w-1:0]       row_tag;
    logic                   valid;
    logic                   last_col;
    logic                   xfer;
    logic                   pop;
    logic                   push_ok;
    logic                   push;

    assign valid    = ~empty;
    assign last_col = (col_idx == col_w'(col - 1));
    assign xfer     = valid & host.o_ready;
    assign pop      = xfer & last_col;
    // A full FIFO still accepts a row on the cycle its head row leaves.
    assign push_ok  = ~full | pop;
    assign push     = out_valid_in & push_ok;

    psum_out_drain_row_fifo #(
        .width (col * bw_psum),
        .depth (depth)
    ) u_row_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (out_in),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_idx  <= '0;
            row_tag  <= '0;
            overflow <= 1'b0;
        end else begin
            if (xfer) begin
                if (last_col) begin
                    col_idx <= '0;
                    row_tag <= row_tag + 1'b1;
                end else begin
                    col_idx <= col_idx + 1'b1;
                end
            end
            if (out_valid_in & ~push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    assign host.o_valid = valid;
    assign host.o_data  = head[col_idx*bw_psum +: bw_psum];
    assign host.o_col   = col_idx;
    assign host.o_row   = row_tag;
    assign host.o_last  = last_col;

endmodule

// File: tb/tb_psum_out_drain.sv
// tb/tb_psum_out_drain.sv - randomized scoreboard bench for psum_out_drain
module tb_psum_out_drain;
    import psum_out_drain_pkg::*;

    localparam int C  = COL;
    localparam int BW = BW_PSUM;
    localparam int D  = PSUM_FIFO_DEPTH;
    localparam int RW = ROW_W;
    localparam int CW = clog2(COL);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [C*BW-1:0] out_in = '0;
    logic            out_valid_in = 1'b0;
    logic            full, empty, overflow;

    psum_out_drain_if host_if ();

    psum_out_drain #(.col(C), .bw_psum(BW), .depth(D), .row_w(RW)) dut (
        .clk          (clk),
        .reset        (reset),
        .out_in       (out_in),
        .out_valid_in (out_valid_in),
        .host         (host_if),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BW-1:0] data;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    beat_t nb;
    beat_t got;
    int    m_rows, m_col, m_tag, m_ovf;
    bit    m_pop;
    int    checks = 0;
    int    errors = 0;
    int    prev_row = -1;
    bit    wrap_seen = 1'b0;

    // Reference: rows are whole units; each accepted row yields C expected beats tagged by acceptance order.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rows = 0; m_col = 0; m_tag = 0; m_ovf = 0;
            exp_q.delete();
        end else begin
            m_pop = 1'b0;
            if (m_rows > 0 && host_if.o_ready) begin
                if (m_col == C - 1) begin
                    m_pop = 1'b1;
                    m_col = 0;
                end else begin
                    m_col = m_col + 1;
                end
            end
            if (out_valid_in) begin
                if (m_rows < D || m_pop) begin
                    for (int k = 0; k < C; k++) begin
                        nb.data = out_in[k*BW +: BW];
                        nb.col  = CW'(k);
                        nb.row  = RW'(m_tag);
                        nb.last = (k == C - 1);
                        exp_q.push_back(nb);
                    end
                    m_tag  = (m_tag + 1) % (1 << RW);
                    m_rows = m_rows + 1;
                end else begin
                    m_ovf = 1;
                end
            end
            if (m_pop) m_rows = m_rows - 1;
        end
    end

    always @(negedge clk) begin
        #1;
        if (!reset) begin
            checks++;
            if (host_if.o_valid !== (m_rows > 0) || empty !== (m_rows == 0) ||
                full !== (m_rows == D) || overflow !== (m_ovf != 0)) begin
                errors++;
                $display("FAIL status: got valid=%0b empty=%0b full=%0b ovf=%0b, expected rows=%0d ovf=%0d",
                         host_if.o_valid, empty, full, overflow, m_rows, m_ovf);
            end
            if (host_if.o_valid) begin
                checks++;
                got = {host_if.o_data, host_if.o_col, host_if.o_row, host_if.o_last};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat: got unexpected beat %h, expected none", got);
                end else begin
                    if (got !== exp_q[0]) begin
                        errors++;
                        $display("FAIL beat: got data=%h col=%0d row=%0d last=%0b, expected data=%h col=%0d row=%0d last=%0b",
                                 got.data, got.col, got.row, got.last,
                                 exp_q[0].data, exp_q[0].col, exp_q[0].row, exp_q[0].last);
                    end
                    if (host_if.o_ready) begin
                        void'(exp_q.pop_front());
                        if (got.last) begin
                            if (prev_row == (1 << RW) - 1 && got.row == 0) wrap_seen = 1'b1;
                            prev_row = int'(got.row);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        out_valid_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        prev_row = -1;
    endtask

    task automatic push_row(input logic [C*BW-1:0] r);
        out_in = r;
        out_valid_in = 1'b1;
        @(negedge clk);
        out_valid_in = 1'b0;
    endtask

    function automatic logic [C*BW-1:0] seq_row();
        logic [C*BW-1:0] r;
        for (int k = 0; k < C; k++) r[k*BW +: BW] = BW'(k + 1);
        return r;
    endfunction

    function automatic logic [C*BW-1:0] rand_row();
        logic [C*BW-1:0] r;
        for (int k = 0; k < C; k++) r[k*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (m_rows > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain", 64'(exp_q.size()) | 64'(m_rows), 64'd0);
    endtask

    initial begin
        bit pat[4];
        int n;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        host_if.o_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            chk("idle_tags", {host_if.o_row, host_if.o_col, host_if.o_last}, 64'd0);
        end

        @(negedge clk);
        host_if.o_ready = 1'b1;
        push_row(seq_row());
        wait_drain(40);

        host_if.o_ready = 1'b0;
        push_row(seq_row());
        for (int i = 0; i < 100 && m_rows > 0; i++) begin
            host_if.o_ready = pat[i % 4];
            @(negedge clk);
        end
        host_if.o_ready = 1'b1;
        wait_drain(40);

        do_reset();
        host_if.o_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_row(rand_row());
        #2;
        chk("full_after_5", {63'd0, full}, 64'd1);
        chk("overflow_after_5", {63'd0, overflow}, 64'd1);
        @(negedge clk);
        host_if.o_ready = 1'b1;
        wait_drain(100);

        do_reset();
        host_if.o_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_row(rand_row());
        host_if.o_ready = 1'b1;
        n = 0;
        while (m_col != C - 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_last_beat", 64'(m_col), 64'(C - 1));
        push_row(rand_row());
        #2;
        chk("pop_push_overflow", {63'd0, overflow}, 64'd0);
        chk("pop_push_full", {63'd0, full}, 64'd1);
        @(negedge clk);
        wait_drain(100);

        do_reset();
        host_if.o_ready = 1'b1;
        push_row(rand_row());
        push_row(rand_row());
        n = 0;
        while (m_col != 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        #1;
        chk("reset_valid_drop", {62'd0, host_if.o_valid, empty}, 64'd1);
        @(negedge clk);
        reset = 1'b0;
        prev_row = -1;
        push_row(seq_row());
        wait_drain(40);

        do_reset();
        for (int i = 0; i < 3500; i++) begin
            host_if.o_ready = ($urandom % 8) != 0;
            out_in = rand_row();
            out_valid_in = ($urandom % 11) == 0;
            @(negedge clk);
        end
        out_valid_in = 1'b0;
        host_if.o_ready = 1'b1;
        wait_drain(200);
        chk("row_tag_wrap", {63'd0, wrap_seen}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no completion, expected finish before 1000000");
        $fatal(1, "timeout");
    end

endmodule
